zubri_host_seq: RTL and testbench

Host-side initiator for the 27-bit word / byte-wide SRAM store controller. It accepts single-word read or write requests on a valid/ready interface and drives the controller's strobe bus (`write`, `parity`, `read`, `out_data`, `in_A`, `in_D`). It uses the controller's address-accepted flag `adrWrite` as handshake and returns read data on a one-cycle response. It sits between system logic (test sequencer, UART command decoder) and the store controller, which runs on its own divided clock.

---
 rtl/zubri_pkg.sv | 25 ++
 rtl/zubri_host_seq_sync2.sv | 20 ++
 rtl/zubri_host_seq.sv | 125 ++++++++++++
 tb/tb_zubri_host_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zubri_pkg.sv
// Shared definitions for the zubri SRAM store host sequencer.
// Holds the word/address widths, the default timing constants (these are
// also used by the controller testbench), the FSM state type and the
// captured-request record.
package zubri_pkg;
  localparam int WORD_W = 27;
  localparam int ADDR_W = 9;
  localparam int CNT_W  = 8;

  localparam int HOLD_CYC_DEF    = 12;
  localparam int WR_WAIT_CYC_DEF = 60;
  localparam int RD_WAIT_CYC_DEF = 42;
  localparam int SETTLE_CYC_DEF  = 18;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR_WAIT, S_RD_WAIT, S_OUT, S_SETTLE, S_DONE
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } req_t;
endpackage

// File: rtl/zubri_host_seq_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous level.
// Ports: clk/rst_n (async active-low), d = async input, q = synchronized output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/zubri_host_seq.sv
// zubri_host_seq: single-word host initiator for the byte-wide SRAM store
// controller. Accepts read/write requests on req_valid/req_ready, sequences
// the controller strobes (write/read, parity, out_data) using the
// synchronized adrWrite flag as the address handshake, and returns a
// one-cycle rsp_valid (with rsp_err on an adrWrite timeout).
// Ports: req_* request side, rsp_* response side, write/read/parity/out_data
// + in_A/in_D towards the controller, out_D/adrWrite from the controller.
module zubri_host_seq
  import zubri_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int WR_WAIT_CYC = WR_WAIT_CYC_DEF,
  parameter int RD_WAIT_CYC = RD_WAIT_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              write,
  output logic              read,
  output logic              parity,
  output logic              out_data,
  output logic [ADDR_W-1:0] in_A,
  output logic [WORD_W-1:0] in_D,
  input  logic [WORD_W-1:0] out_D,
  input  logic              adrWrite
);
  localparam logic [CNT_W-1:0] HOLD_L    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] WR_WAIT_L = CNT_W'(WR_WAIT_CYC);
  localparam logic [CNT_W-1:0] RD_WAIT_L = CNT_W'(RD_WAIT_CYC);
  localparam logic [CNT_W-1:0] SETTLE_L  = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT_CYC);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  req_t             cur;
  logic             adr_s;
  logic             accept;
  logic             last;

  sync2 u_adr_sync (.clk(clk), .rst_n(rst_n), .d(adrWrite), .q(adr_s));

  assign accept = (state_q == S_IDLE) && req_valid;
  // Timed states run for exactly the loaded count: the count seen in the
  // final cycle is 1, and the transition takes it to the next load.
  assign last   = (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      cur      <= '0;
      rsp_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        cur.write <= req_write;
        cur.addr  <= req_addr;
        cur.data  <= req_data;
      end
      if (state_q == S_SETTLE && last) rsp_data <= out_D;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_ADDR;
        cnt_d   = TIMEOUT_L;
        err_d   = 1'b0;
      end
      S_ADDR: begin
        if (adr_s) begin
          state_d = cur.write ? S_DATA : S_RD_WAIT;
          cnt_d   = cur.write ? HOLD_L : RD_WAIT_L;
        end else if (cnt_q == '0) begin
          // timeout counts down through zero, so ADDR lasts TIMEOUT+1 cycles
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA:    if (last) begin state_d = S_WR_WAIT; cnt_d = WR_WAIT_L; end
                 else cnt_d = cnt_q - CNT_W'(1);
      S_WR_WAIT: if (last) state_d = S_DONE;
                 else cnt_d = cnt_q - CNT_W'(1);
      S_RD_WAIT: if (last) begin state_d = S_OUT; cnt_d = HOLD_L; end
                 else cnt_d = cnt_q - CNT_W'(1);
      S_OUT:     if (last) begin state_d = S_SETTLE; cnt_d = SETTLE_L; end
                 else cnt_d = cnt_q - CNT_W'(1);
      S_SETTLE:  if (last) state_d = S_DONE;
                 else cnt_d = cnt_q - CNT_W'(1);
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset
  // clears them immediately; one state per strobe keeps them exclusive.
  assign req_ready = (state_q == S_IDLE);
  assign write     = (state_q == S_ADDR) &&  cur.write;
  assign read      = (state_q == S_ADDR) && !cur.write;
  assign parity    = (state_q == S_DATA);
  assign out_data  = (state_q == S_OUT);
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_err   = (state_q == S_DONE) && err_q;
  assign in_A      = cur.addr;
  assign in_D      = cur.data;
endmodule

// File: tb/tb_zubri_host_seq.sv
// Bench for zubri_host_seq: a behavioural store controller (memory, delayed
// adrWrite ack, out_D drive) plus a response scoreboard and strobe monitors.
module tb_zubri_host_seq;
  localparam int HOLD = 12, WRW = 60, RDW = 42, SETL = 18, TMO = 255;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [26:0] req_data = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [26:0] rsp_data;
  logic        write, read, parity, out_data;
  logic [8:0]  in_A;
  logic [26:0] in_D;
  logic [26:0] out_D = '0;
  logic        adrWrite = 1'b0;

  zubri_host_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .write(write), .read(read), .parity(parity), .out_data(out_data),
    .in_A(in_A), .in_D(in_D), .out_D(out_D), .adrWrite(adrWrite)
  );

  always #10 clk = ~clk;

  typedef struct { logic err; logic [26:0] data; } exp_t;
  exp_t        sb[$];
  exp_t        e_pop;
  logic [26:0] ref_mem [512];
  logic [26:0] cmem [512];
  logic [26:0] exp_last = '0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0;
  int wr_run = 0, rd_run = 0, par_run = 0, out_run = 0;
  int wr_len = 0, rd_len = 0, par_len = 0, out_len = 0;
  int ovl = 0, stab_err = 0, hi_cnt = 0;
  bit busy = 0, ack_en = 0;
  int ack_dly = 1;
  logic [8:0]  capA;
  logic [26:0] capD;

  bit          bw [3] = '{1'b1, 1'b1, 1'b0};
  logic [8:0]  ba [3] = '{9'h001, 9'h1FF, 9'h1FF};
  logic [26:0] bd [3] = '{27'h0000001, 27'h7FFFFFF, 27'h0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // controller model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (write || read) begin
      hi_cnt++;
      if (ack_en && hi_cnt == ack_dly) adrWrite <= 1'b1;
    end else begin
      hi_cnt = 0;
      adrWrite <= 1'b0;
    end
    if (parity)   cmem[in_A] <= in_D;
    if (out_data) out_D <= cmem[in_A];
  end

  // monitors and scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if ((int'(write) + int'(read) + int'(parity) + int'(out_data)) > 1) ovl++;
      if (write) wr_run++;    else if (wr_run != 0)  begin wr_len = wr_run;   wr_run = 0;  end
      if (read) rd_run++;     else if (rd_run != 0)  begin rd_len = rd_run;   rd_run = 0;  end
      if (parity) par_run++;  else if (par_run != 0) begin par_len = par_run; par_run = 0; end
      if (out_data) out_run++; else if (out_run != 0) begin out_len = out_run; out_run = 0; end
      if (!req_ready) begin
        if (!busy) begin busy = 1; capA = in_A; capD = in_D; end
        else if (in_A !== capA || in_D !== capD) stab_err++;
      end else busy = 0;
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL rsp_extra: observed response at cycle %0d expected none", cyc);
        end
        if (sb.size() > 0) begin
          e_pop = sb.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e_pop.err));
          chk("rsp_data", 32'(rsp_data), 32'(e_pop.data));
        end
      end
    end else begin
      wr_run = 0; rd_run = 0; par_run = 0; out_run = 0; busy = 0;
    end
  end

  function automatic void push(input bit wr, input logic [8:0] a, input logic [26:0] d, input bit abort);
    exp_t e;
    e.err = abort;
    if (!abort && wr)  ref_mem[a] = d;
    if (!abort && !wr) exp_last = ref_mem[a];
    e.data = exp_last;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!req_ready && k < 2000) begin tick(); k++; end
    chk("ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (rsp_cnt < target && k < 3000) begin tick(); k++; end
    chk("rsp_wait", 32'(rsp_cnt >= target), 32'd1);
  endtask

  // drive one request, accept it, and drop req_valid right after
  task automatic issue(input bit wr, input logic [8:0] a, input logic [26:0] d,
                       input bit ack_on, input int dly);
    wait_ready();
    ack_en = ack_on; ack_dly = dly;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_data = d;
    @(posedge clk); #1;
    acc_cyc = cyc;
    push(wr, a, d, !ack_on);
    req_valid = 1'b0;
  endtask

  initial begin
    int rc, k, ready_hi;
    for (int i = 0; i < 512; i++) begin ref_mem[i] = '0; cmem[i] = '0; end
    repeat (3) tick();
    // reset state
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", 32'({write, read, parity, out_data}), 32'd0);
    chk("rst_in_A", 32'(in_A), 32'd0);
    chk("rst_in_D", 32'(in_D), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // write 0x05A, ack at edge 7 after acceptance
    rc = rsp_cnt;
    issue(1'b1, 9'h05A, 27'h5ABCDEF, 1'b1, 7);
    wait_rsp(rc + 1);
    // latencies below count the accepting cycle as cycle 1
    chk("wr_lat", 32'(rsp_cyc - acc_cyc), 32'(1 + 7 + 3 + HOLD + WRW - 1));
    chk("wr_len", 32'(wr_len), 32'd10);
    chk("par_len", 32'(par_len), 32'(HOLD));
    chk("cmem_05A", 32'(cmem[9'h05A]), 32'h5ABCDEF);

    // read back 0x05A
    rc = rsp_cnt;
    issue(1'b0, 9'h05A, 27'h0, 1'b1, 7);
    wait_rsp(rc + 1);
    chk("rd_lat", 32'(rsp_cyc - acc_cyc), 32'(1 + 7 + 3 + RDW + HOLD + SETL - 1));
    chk("out_len", 32'(out_len), 32'(HOLD));
    repeat (10) tick();
    chk("rd_single", 32'(rsp_cnt - rc), 32'd1);

    // read 0x1FF with no ack -> timeout
    rc = rsp_cnt;
    issue(1'b0, 9'h1FF, 27'h0, 1'b0, 1);
    wait_rsp(rc + 1);
    chk("tmo_lat", 32'(rsp_cyc - acc_cyc), 32'(TMO + 2 - 1));
    chk("tmo_rd_len", 32'(rd_len), 32'(TMO + 1));
    chk("tmo_rsp_data", 32'(rsp_data), 32'h5ABCDEF);

    // three back-to-back requests with req_valid held high
    rc = rsp_cnt;
    ack_en = 1'b1; ack_dly = 2;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_write = bw[i]; req_addr = ba[i]; req_data = bd[i];
      wait_ready();
      @(posedge clk); #1;
      push(bw[i], ba[i], bd[i], 1'b0);
    end
    req_valid = 1'b0;
    wait_rsp(rc + 3);
    repeat (20) tick();
    chk("b2b_count", 32'(rsp_cnt - rc), 32'd3);
    chk("b2b_last", 32'(rsp_data), 32'h7FFFFFF);

    // reset during DATA
    issue(1'b1, 9'h0AA, 27'h1234567, 1'b1, 3);
    k = 0;
    while (!parity && k < 200) begin tick(); k++; end
    chk("in_data", 32'(parity), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_parity_drop", 32'(parity), 32'd0);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    sb.delete();
    exp_last = '0;
    tick();
    rst_n = 1'b1;
    rc = rsp_cnt;
    repeat (100) tick();
    chk("rst_no_rsp", 32'(rsp_cnt - rc), 32'd0);
    chk("rst_ready_after", 32'(req_ready), 32'd1);

    // random req_valid while busy: write then read of 0x0C3
    for (int t = 0; t < 2; t++) begin
      rc = rsp_cnt;
      ready_hi = 0;
      issue(t == 0, 9'h0C3, 27'h2C3A5F1, 1'b1, 1 + t * 4);
      k = 0;
      while (k < 1000) begin
        tick(); k++;
        if (rsp_cnt > rc) break;
        if (req_ready) ready_hi++;
        req_valid = 1'($urandom_range(1));
        req_write = 1'($urandom_range(1));
        req_addr  = 9'($urandom);
        req_data  = 27'($urandom);
      end
      req_valid = 1'b0;
      chk("busy_ready_low", 32'(ready_hi), 32'd0);
      repeat (10) tick();
      chk("busy_single_rsp", 32'(rsp_cnt - rc), 32'd1);
    end
    chk("busy_rd_data", 32'(rsp_data), 32'h2C3A5F1);

    chk("strobe_overlap", 32'(ovl), 32'd0);
    chk("inAD_stable", 32'(stab_err), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
